axis_rr_merge: RTL and testbench
================================

Name: axis_rr_merge

Overview:
- Single-clock, N-channel AXI-stream merge. Round-robin arbitration feeds one registered output stream, and each output beat carries its source channel index.
- Generalises the team's single-value stream transfer in three ways: channel count, data width, and an optional packet-atomic mode.
- Sits after per-channel CDC transfer blocks, in the destination clock domain, to funnel their outputs into one consumer.

Parameters:
- NCH, 4, number of input channels, range 2..16.
- W, 32, data width per channel, minimum 1.
- LGCH, $clog2(NCH), width of channel index. Derived; not to be overridden.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_reset_n  in  1  reset, asynchronous assert, active-low.
- i_valid  in  NCH  per-channel valid.
- o_ready  out  NCH  per-channel ready.
- i_data  in  NCH*W  channel k occupies bits [k*W +: W].
- i_last  in  NCH  per-channel end-of-packet; used only with AXIS_RR_MERGE_PKT_EN.
- o_valid  out  1  output valid, registered.
- i_ready  in  1  downstream ready.
- o_data  out  W  output data, registered.
- o_chan  out  LGCH  source channel of the current beat, registered.
- o_last  out  1  end-of-packet, registered.

Behaviour:
- Reset (async, i_reset_n low): o_valid=0, o_data=0, o_chan=0, o_last=0, r_prev=NCH-1, r_lock=0. Channel 0 therefore has first priority after reset.
- Slot free: slot_free = !o_valid || i_ready.
- Grant (combinational): first k with i_valid[k], searching r_prev+1, r_prev+2, ... and wrapping modulo NCH. NCH that is not a power of two must wrap correctly; indices >= NCH are never granted.
- o_ready: o_ready[k] = slot_free && (k == grant) && any_valid. At most one bit is set. o_ready never depends on i_valid of a non-granted channel being stable.
- Accept: when i_valid[k] && o_ready[k]:
  - next cycle o_valid=1, o_data=i_data[k], o_chan=k, o_last as below.
  - r_prev <= k.
- Latency: 1 cycle input-to-output. Full throughput of 1 beat/cycle with i_ready held high.
- Downstream stall: if o_valid && !i_ready, then o_valid, o_data, o_chan, o_last are held unchanged and all o_ready=0.
- Idle: if slot_free && no i_valid, then o_valid <= 0. o_data and o_chan hold their last values.
- Fairness: any channel held valid is accepted within NCH accepted beats (non-packet mode).
- Simultaneous events: a new beat is accepted in the same cycle the current beat drains via i_ready=1. No bubble is inserted.
- Reset mid-transfer: an in-flight beat is dropped and o_valid falls immediately (async). Arbitration restarts at channel 0.
- Input-side rule: upstream must hold i_valid and data stable while waiting. The block makes no assumption of fairness from upstream.
- Outgoing-stream obligation: standard AXI-stream output; once o_valid is high, it and all o_* stay stable until i_ready.

Optional Feature:
- Macro: AXIS_RR_MERGE_PKT_EN.
- Defined (packet-atomic mode):
  - Accepting a beat with i_last[k]=0 sets r_lock=1 and locks the grant to k. Only channel k can receive o_ready, even if k drops i_valid.
  - Accepting a beat with i_last[k]=1 clears r_lock. Round-robin then resumes from k+1.
  - o_last = i_last of the accepted beat.
- Undefined:
  - i_last is ignored, r_lock is absent, and o_last is registered as 1 on every accepted beat. Its reset value is still 0.

Test Plan:
- Reset release, all i_valid=0, i_ready=1 -> o_valid=0 and o_ready=0000 for 10 cycles. After reset, i_valid=1111 -> o_chan sequence 0,1,2,3,0,1..., one beat per cycle.
- NCH=3 with i_valid=101 held -> o_chan alternates 0,2,0,2. Index 3 is never produced; o_data matches the channel's data word each time.
- Channel 1 sends 0xDEADBEEF, i_ready=0 for 5 cycles -> o_valid=1, o_data=0xDEADBEEF, o_chan=1 stable throughout, o_ready=0000. i_ready=1 -> drained, and the next grant is the channel after 1.
- Back-to-back: channels 0 and 2 valid, i_ready toggling 1,0,1,0 -> no beat lost or duplicated. Scoreboard of (chan, data) pairs matches input order per channel.
- i_reset_n pulsed low mid-stream while o_valid=1 -> o_valid=0 in the same cycle, without waiting for a clock. Next grant is channel 0.
- With AXIS_RR_MERGE_PKT_EN: channel 2 sends a 3-beat packet (last on beat 3) while channel 0 is continuously valid -> o_chan=2,2,2 with o_last=0,0,1, then 0. Channel 2 dropping valid mid-packet leaves o_ready[0]=0.

Source files
------------

// File: rtl/axis_rr_merge.sv
// axis_rr_merge: N-channel AXI-stream round-robin merge onto one registered output stream.
// Optional packet-atomic arbitration is enabled by defining AXIS_RR_MERGE_PKT_EN.
`default_nettype none

module axis_rr_merge #(
    parameter int NCH  = 4,
    parameter int W    = 32,
    parameter int LGCH = $clog2(NCH)
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic [NCH-1:0]    i_valid,
    output logic [NCH-1:0]    o_ready,
    input  logic [NCH*W-1:0]  i_data,
    input  logic [NCH-1:0]    i_last,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [W-1:0]      o_data,
    output logic [LGCH-1:0]   o_chan,
    output logic              o_last
);

    // Channel vectors padded to a power of two so any LGCH-bit index is legal.
    localparam int NPAD = 1 << LGCH;

    logic              slot_free;
    logic              any_valid;
    logic              accept;
    logic              found;
    logic [LGCH-1:0]   cand;
    logic [LGCH-1:0]   rr_grant;
    logic [LGCH-1:0]   grant;
    logic [LGCH-1:0]   r_prev;
    logic [NPAD-1:0]   valid_pad;
    logic [W-1:0]      data_arr [NPAD];

`ifdef AXIS_RR_MERGE_PKT_EN
    logic              r_lock;
    logic [NPAD-1:0]   last_pad;

    always_comb begin
        last_pad = '0;
        for (int k = 0; k < NCH; k++) begin
            last_pad[k] = i_last[k];
        end
    end
`else
    logic              unused_last;
    assign unused_last = ^i_last;
`endif

    always_comb begin
        valid_pad = '0;
        for (int k = 0; k < NPAD; k++) begin
            data_arr[k] = '0;
        end
        for (int k = 0; k < NCH; k++) begin
            valid_pad[k] = i_valid[k];
            data_arr[k]  = i_data[k*W +: W];
        end
    end

    // Search starts just after the last granted channel and wraps modulo NCH.
    always_comb begin
        rr_grant = r_prev;
        found    = 1'b0;
        cand     = '0;
        for (int s = 1; s <= NCH; s++) begin
            cand = LGCH'((int'(r_prev) + s) % NCH);
            if (!found && valid_pad[cand]) begin
                found    = 1'b1;
                rr_grant = cand;
            end
        end
    end

`ifdef AXIS_RR_MERGE_PKT_EN
    assign grant = r_lock ? r_prev : rr_grant;
`else
    assign grant = rr_grant;
`endif

    assign any_valid = |i_valid;
    assign slot_free = !o_valid || i_ready;
    assign accept    = slot_free && valid_pad[grant];

    always_comb begin
        o_ready = '0;
        for (int k = 0; k < NCH; k++) begin
            if (slot_free && any_valid && (grant == LGCH'(k))) begin
                o_ready[k] = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid <= 1'b0;
            o_data  <= '0;
            o_chan  <= '0;
            o_last  <= 1'b0;
            r_prev  <= LGCH'(NCH - 1);
`ifdef AXIS_RR_MERGE_PKT_EN
            r_lock  <= 1'b0;
`endif
        end else if (slot_free) begin
            if (accept) begin
                o_valid <= 1'b1;
                o_data  <= data_arr[grant];
                o_chan  <= grant;
                r_prev  <= grant;
`ifdef AXIS_RR_MERGE_PKT_EN
                o_last  <= last_pad[grant];
                r_lock  <= !last_pad[grant];
`else
                o_last  <= 1'b1;
`endif
            end else begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_axis_rr_merge.sv
// tb_axis_rr_merge: checks a 4-channel and a 3-channel merge against a queue-free rule model.
`default_nettype none

module tb_axis_rr_merge;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic chk_en = 1'b0;
    always #5 clk = ~clk;

    logic [3:0]  vin [2];
    logic [3:0]  lin [2];
    logic        rin [2];
    logic [31:0] din [2][4];

    logic [127:0] dflat0;
    logic [95:0]  dflat1;
    assign dflat0 = {din[0][3], din[0][2], din[0][1], din[0][0]};
    assign dflat1 = {din[1][2], din[1][1], din[1][0]};

    logic [3:0]  ordy0;
    logic [2:0]  ordy3;
    logic        ov0, ov1, ol0, ol1;
    logic [31:0] od0, od1;
    logic [1:0]  oc0, oc1;

    axis_rr_merge #(.NCH(4), .W(32)) dut0 (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(vin[0]), .o_ready(ordy0),
        .i_data(dflat0), .i_last(lin[0]), .o_valid(ov0), .i_ready(rin[0]),
        .o_data(od0), .o_chan(oc0), .o_last(ol0)
    );

    axis_rr_merge #(.NCH(3), .W(32)) dut1 (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(vin[1][2:0]), .o_ready(ordy3),
        .i_data(dflat1), .i_last(lin[1][2:0]), .o_valid(ov1), .i_ready(rin[1]),
        .o_data(od1), .o_chan(oc1), .o_last(ol1)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: registered output beat plus last granted channel and packet lock.
    logic        m_ov   [2];
    logic [31:0] m_od   [2];
    int          m_oc   [2];
    logic        m_ol   [2];
    int          m_prev [2];
    logic        m_lock [2];

    function automatic logic [3:0] exp_ready(input int u);
        int   n;
        logic any;
        n   = (u == 0) ? 4 : 3;
        any = 1'b0;
        for (int k = 0; k < n; k++) any |= vin[u][k];
        if (m_ov[u] && !rin[u]) return 4'b0;
        if (!any) return 4'b0;
        if (m_lock[u]) return 4'b0001 << m_prev[u];
        for (int s = 1; s <= n; s++)
            if (vin[u][(m_prev[u] + s) % n]) return 4'b0001 << ((m_prev[u] + s) % n);
        return 4'b0;
    endfunction

    function automatic int first_idx(input logic [3:0] r);
        for (int k = 0; k < 4; k++) if (r[k]) return k;
        return 0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int u = 0; u < 2; u++) begin
            if (!rst_n) begin
                m_ov[u]   <= 1'b0;
                m_od[u]   <= 32'h0;
                m_oc[u]   <= 0;
                m_ol[u]   <= 1'b0;
                m_prev[u] <= ((u == 0) ? 4 : 3) - 1;
                m_lock[u] <= 1'b0;
            end else if (!m_ov[u] || rin[u]) begin
                if ((exp_ready(u) & vin[u]) != 4'b0) begin
                    m_ov[u]   <= 1'b1;
                    m_oc[u]   <= first_idx(exp_ready(u));
                    m_od[u]   <= din[u][first_idx(exp_ready(u))];
                    m_prev[u] <= first_idx(exp_ready(u));
`ifdef AXIS_RR_MERGE_PKT_EN
                    m_ol[u]   <= lin[u][first_idx(exp_ready(u))];
                    m_lock[u] <= !lin[u][first_idx(exp_ready(u))];
`else
                    m_ol[u]   <= 1'b1;
`endif
                end else begin
                    m_ov[u] <= 1'b0;
                end
            end
        end
    end

    task automatic cmp(input int u, input logic v, input logic [31:0] d, input logic [1:0] c,
                       input logic l, input logic [3:0] r);
        chk($sformatf("u%0d_valid", u), 64'(v), 64'(m_ov[u]));
        chk($sformatf("u%0d_data", u),  64'(d), 64'(m_od[u]));
        chk($sformatf("u%0d_chan", u),  64'(c), 64'(m_oc[u]));
        chk($sformatf("u%0d_last", u),  64'(l), 64'(m_ol[u]));
        chk($sformatf("u%0d_ready", u), 64'(r), 64'(exp_ready(u)));
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            cmp(0, ov0, od0, oc0, ol0, ordy0);
            cmp(1, ov1, od1, oc1, ol1, {1'b0, ordy3});
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int u = 0; u < 2; u++) begin
            vin[u] = 4'b0;
            lin[u] = 4'b1111;
            rin[u] = 1'b1;
            for (int k = 0; k < 4; k++) din[u][k] = 32'h0;
        end
        #1 rst_n = 1'b0;
        #1 chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle after reset
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("idle_valid", 64'(ov0), 64'h0);
            chk("idle_ready", 64'(ordy0), 64'h0);
        end

        // All four channels valid: strict rotation from channel 0
        for (int k = 0; k < 4; k++) din[0][k] = 32'h100 + k;
        vin[0] = 4'b1111;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("rr4_chan", 64'(oc0), 64'(i % 4));
            chk("rr4_data", 64'(od0), 64'(32'h100 + i % 4));
        end
        vin[0] = 4'b0;
        cyc(); cyc();

        // Three channels, 0 and 2 valid: wrap never yields index 3
        din[1][0] = 32'hA0;
        din[1][2] = 32'hA2;
        vin[1] = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            cyc();
            chk("rr3_chan", 64'(oc1), (i % 2) ? 64'd2 : 64'd0);
            chk("rr3_data", 64'(od1), (i % 2) ? 64'hA2 : 64'hA0);
        end
        vin[1] = 4'b0;
        cyc(); cyc();

        // Downstream stall holds the beat and blocks all readies
        din[0][1] = 32'hDEADBEEF;
        vin[0] = 4'b0010;
        rin[0] = 1'b0;
        cyc();
        vin[0] = 4'b1101;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("stall_valid", 64'(ov0), 64'h1);
            chk("stall_data", 64'(od0), 64'hDEADBEEF);
            chk("stall_chan", 64'(oc0), 64'h1);
            chk("stall_ready", 64'(ordy0), 64'h0);
        end
        rin[0] = 1'b1;
        cyc();
        chk("drain_next_chan", 64'(oc0), 64'h2);
        chk("drain_next_data", 64'(od0), 64'h102);
        vin[0] = 4'b0;
        cyc(); cyc();

        // Toggling downstream ready with channels 0 and 2 valid
        vin[0] = 4'b0101;
        for (int i = 0; i < 8; i++) begin
            rin[0] = (i % 2 == 0);
            cyc();
        end
        vin[0] = 4'b0;
        rin[0] = 1'b1;
        cyc(); cyc();

        // Asynchronous reset while a beat is in flight
        vin[0] = 4'b1111;
        cyc(); cyc();
        chk("pre_rst_valid", 64'(ov0), 64'h1);
        #1 rst_n = 1'b0;
        #1 chk("async_rst_valid", 64'(ov0), 64'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        cyc();
        chk("post_rst_valid", 64'(ov0), 64'h1);
        chk("post_rst_chan", 64'(oc0), 64'h0);
        vin[0] = 4'b0;
        cyc(); cyc();

`ifdef AXIS_RR_MERGE_PKT_EN
        // Packet lock: channel 2 sends three beats while channel 0 stays valid
        din[0][1] = 32'h111;
        vin[0] = 4'b0010;
        lin[0] = 4'b1111;
        cyc();
        din[0][2] = 32'h200;
        lin[0] = 4'b1011;
        vin[0] = 4'b0101;
        cyc();
        chk("pkt_b0_chan", 64'(oc0), 64'h2);
        chk("pkt_b0_last", 64'(ol0), 64'h0);
        vin[0][2] = 1'b0;
        #1 chk("pkt_lock_ready0", 64'(ordy0[0]), 64'h0);
        cyc();
        chk("pkt_gap_valid", 64'(ov0), 64'h0);
        vin[0][2] = 1'b1;
        din[0][2] = 32'h201;
        cyc();
        chk("pkt_b1_chan", 64'(oc0), 64'h2);
        chk("pkt_b1_data", 64'(od0), 64'h201);
        chk("pkt_b1_last", 64'(ol0), 64'h0);
        din[0][2] = 32'h202;
        lin[0][2] = 1'b1;
        cyc();
        chk("pkt_b2_chan", 64'(oc0), 64'h2);
        chk("pkt_b2_last", 64'(ol0), 64'h1);
        vin[0][2] = 1'b0;
        cyc();
        chk("pkt_after_chan", 64'(oc0), 64'h0);
        chk("pkt_after_last", 64'(ol0), 64'h1);
        vin[0] = 4'b0;
        cyc(); cyc();
`endif

        chk_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
